ddr_cmd_sched: RTL and testbench

Command-sequencing stage that sits directly upstream of the burst-data/pin-driver stage. It accepts one read or write request at a time from the simulation model. It then produces the one-cycle `act_rdy`, `cas_rdy`, `rw_rdy` and `refresh_rdy` strobes that the downstream stage uses to pop its CAS and data queues. The strobes are spaced to honour tRCD, tCCD, read/write latency and periodic refresh.

---
 rtl/ddr_cmd_sched.sv | 241 ++++++++++++++++++++++++
 tb/tb_ddr_cmd_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_cmd_sched.sv
// ddr_cmd_sched: ACT/CAS/data-phase/refresh strobe sequencer in front of the
// burst-data stage. One request in flight through ACT..CAS at a time; data
// phases are tracked in SLOTS countdown entries and always retire in order.
// Optional refresh logic: define DDR_SCHED_REFRESH_EN to build it.

// One data-phase entry: {remaining count, type}; fires when the count hits 0.
module ddr_cmd_sched_slot (
    input  logic       clock_t,
    input  logic       reset,
    input  logic       load,
    input  logic [5:0] load_cnt,
    input  logic [1:0] load_type,
    output logic       vld,
    output logic       fire,
    output logic [1:0] typ
);
    logic       vld_q, vld_d;
    logic [5:0] cnt_q, cnt_d;
    logic [1:0] typ_q, typ_d;

    // load wins; a firing entry frees itself; otherwise count down
    always_comb begin
        vld_d = vld_q;
        cnt_d = cnt_q;
        typ_d = typ_q;
        if (load) begin
            vld_d = 1'b1;
            cnt_d = load_cnt;
            typ_d = load_type;
        end else if (vld_q) begin
            if (cnt_q == 6'd0) vld_d = 1'b0;
            else               cnt_d = cnt_q - 6'd1;
        end
    end

    // entry registers
    always_ff @(posedge clock_t) begin
        if (reset) begin
            vld_q <= 1'b0;
            cnt_q <= 6'd0;
            typ_q <= 2'b00;
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            typ_q <= typ_d;
        end
    end

    assign vld  = vld_q;
    assign fire = vld_q && (cnt_q == 6'd0);
    assign typ  = typ_q;
endmodule

module ddr_cmd_sched #(
    parameter int T_RCD  = 11,
    parameter int T_REFI = 7800,
    parameter int T_RFC  = 260,
    parameter int SLOTS  = 4
) (
    input  logic       clock_t,
    input  logic       reset,
    input  logic       new_cmd,
    input  logic [1:0] req_rw,
    output logic       req_ready,
    input  logic [5:0] rd_delay,
    input  logic [5:0] wr_delay,
    input  logic [3:0] t_ccd,
    output logic       act_rdy,
    output logic       cas_rdy,
    output logic [1:0] cas_rw,
    output logic       rw_rdy,
    output logic [1:0] rw_type,
    output logic       refresh_rdy,
    output logic       busy
);
`ifdef DDR_SCHED_REFRESH_EN
    typedef enum logic [2:0] {S_IDLE, S_ACT, S_RCD_WAIT, S_CAS, S_REF, S_RFC_WAIT} state_t;
    localparam int WAIT_MAX = (T_RCD > T_RFC) ? T_RCD : T_RFC;
    localparam int RFW      = $clog2(T_REFI + 1);
`else
    typedef enum logic [1:0] {S_IDLE, S_ACT, S_RCD_WAIT, S_CAS} state_t;
    localparam int WAIT_MAX = T_RCD;
`endif
    localparam int WW = $clog2(WAIT_MAX + 1);

    state_t              state_q, state_d;
    logic [WW-1:0]       wait_q, wait_d;
    logic [1:0]          rw_q, rw_d;          // type of the request in flight
    logic [3:0]          ccd_cnt_q, ccd_cnt_d; // cycles since last CAS, saturating
    logic [3:0]          ccd_lat_q, ccd_lat_d; // t_ccd captured at last CAS
    logic [5:0]          last_rem_q, last_rem_d; // cycles until last scheduled data phase

    logic                is_valid, ccd_ok, order_ok, cas_go, ref_pend, found;
    logic [5:0]          d_raw, d_eff;
    logic [SLOTS-1:0]    slot_vld, slot_fire, load_vec;
    logic [SLOTS-1:0][1:0] slot_typ;
    logic [1:0]          rw_type_c;

    // CAS gating: tCCD spacing and strictly increasing data cycles
    always_comb begin
        is_valid = (rw_q == 2'b01) || (rw_q == 2'b10);
        d_raw    = (rw_q == 2'b10) ? wr_delay : rd_delay;
        d_eff    = (d_raw == 6'd0) ? 6'd1 : d_raw;
        ccd_ok   = ccd_cnt_q >= ccd_lat_q;
        order_ok = !is_valid || (d_eff > last_rem_q);
        cas_go   = (state_q == S_CAS) && ccd_ok && order_ok;
    end

    // pick the lowest entry that is free or freeing this cycle
    always_comb begin
        load_vec = '0;
        found    = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!found && (!slot_vld[i] || slot_fire[i])) begin
                load_vec[i] = cas_go && is_valid;
                found       = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        ddr_cmd_sched_slot u_slot (
            .clock_t   (clock_t),
            .reset     (reset),
            .load      (load_vec[g]),
            .load_cnt  (d_eff - 6'd1),
            .load_type (rw_q),
            .vld       (slot_vld[g]),
            .fire      (slot_fire[g]),
            .typ       (slot_typ[g])
        );
    end

    // merge the (at most one) firing entry's type
    always_comb begin
        rw_type_c = 2'b00;
        for (int i = 0; i < SLOTS; i++)
            if (slot_fire[i]) rw_type_c = rw_type_c | slot_typ[i];
    end

`ifdef DDR_SCHED_REFRESH_EN
    logic [RFW-1:0] ref_cnt_q, ref_cnt_d;

    // refresh interval counter: holds at T_REFI-1 (pending) until REF issues
    always_comb begin
        ref_pend  = (ref_cnt_q == RFW'(T_REFI - 1));
        ref_cnt_d = ref_cnt_q;
        if (state_q == S_REF) ref_cnt_d = '0;
        else if (!ref_pend)   ref_cnt_d = ref_cnt_q + RFW'(1);
    end

    // refresh counter register
    always_ff @(posedge clock_t) begin
        if (reset) ref_cnt_q <= '0;
        else       ref_cnt_q <= ref_cnt_d;
    end

    assign refresh_rdy = (state_q == S_REF) && !reset;
`else
    logic unused_cfg;
    assign unused_cfg  = ^{T_REFI[0], T_RFC[0]};
    assign ref_pend    = 1'b0;
    assign refresh_rdy = 1'b0;
`endif

    assign req_ready = (state_q == S_IDLE) && !(&slot_vld) && !ref_pend && !reset;

    // sequencer next state plus tCCD / ordering bookkeeping
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        rw_d       = rw_q;
        ccd_cnt_d  = (ccd_cnt_q == 4'd15) ? ccd_cnt_q : ccd_cnt_q + 4'd1;
        ccd_lat_d  = ccd_lat_q;
        last_rem_d = (last_rem_q == 6'd0) ? 6'd0 : last_rem_q - 6'd1;
        case (state_q)
            S_IDLE: begin
                if (new_cmd && req_ready) begin
                    state_d = S_ACT;
                    rw_d    = req_rw;
                end
`ifdef DDR_SCHED_REFRESH_EN
                else if (ref_pend && !(|slot_vld)) state_d = S_REF;
`endif
            end
            S_ACT: begin
                state_d = S_RCD_WAIT;
                wait_d  = '0;
            end
            S_RCD_WAIT: begin
                if (wait_q == WW'(T_RCD - 2)) state_d = S_CAS;
                else                          wait_d  = wait_q + WW'(1);
            end
            S_CAS: begin
                if (cas_go) state_d = S_IDLE;
            end
`ifdef DDR_SCHED_REFRESH_EN
            S_REF: begin
                state_d = S_RFC_WAIT;
                wait_d  = '0;
            end
            S_RFC_WAIT: begin
                if (wait_q == WW'(T_RFC - 2)) state_d = S_IDLE;
                else                          wait_d  = wait_q + WW'(1);
            end
`endif
            default: state_d = S_IDLE;
        endcase
        if (cas_go) begin
            ccd_cnt_d = 4'd1;
            ccd_lat_d = t_ccd;
            if (is_valid) last_rem_d = d_eff - 6'd1;
        end
    end

    // sequencer registers; reset leaves tCCD satisfied
    always_ff @(posedge clock_t) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_q     <= '0;
            rw_q       <= 2'b00;
            ccd_cnt_q  <= 4'd0;
            ccd_lat_q  <= 4'd0;
            last_rem_q <= 6'd0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            rw_q       <= rw_d;
            ccd_cnt_q  <= ccd_cnt_d;
            ccd_lat_q  <= ccd_lat_d;
            last_rem_q <= last_rem_d;
        end
    end

    assign act_rdy = (state_q == S_ACT) && !reset;
    assign cas_rdy = cas_go && !reset;
    assign cas_rw  = (cas_rdy && is_valid) ? rw_q : 2'b00;
    assign rw_rdy  = (|slot_fire) && !reset;
    assign rw_type = rw_rdy ? rw_type_c : 2'b00;
    assign busy    = ((state_q != S_IDLE) || (|slot_vld)) && !reset;
endmodule

// File: tb/tb_ddr_cmd_sched.sv
// Directed bench for ddr_cmd_sched: T_RCD=11, SLOTS=4, T_REFI=200, T_RFC=20.
module tb_ddr_cmd_sched;
    typedef struct {
        int         cyc;
        logic [1:0] t;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       new_cmd = 1'b0;
    logic [1:0] req_rw = 2'b00;
    logic [5:0] rd_delay = 6'd14;
    logic [5:0] wr_delay = 6'd10;
    logic [3:0] t_ccd = 4'd4;
    logic       req_ready, act_rdy, cas_rdy, rw_rdy, refresh_rdy, busy;
    logic [1:0] cas_rw, rw_type;

    int  cyc = 0;
    int  n_chk = 0;
    int  n_err = 0;
    int  excl_bad = 0;
    int  act_ev[$];
    int  ref_ev[$];
    ev_t cas_ev[$];
    ev_t rw_ev[$];
    logic rdy_log [0:299];

    ddr_cmd_sched #(.T_RCD(11), .T_REFI(200), .T_RFC(20), .SLOTS(4)) dut (
        .clock_t     (clk),
        .reset       (reset),
        .new_cmd     (new_cmd),
        .req_rw      (req_rw),
        .req_ready   (req_ready),
        .rd_delay    (rd_delay),
        .wr_delay    (wr_delay),
        .t_ccd       (t_ccd),
        .act_rdy     (act_rdy),
        .cas_rdy     (cas_rdy),
        .cas_rw      (cas_rw),
        .rw_rdy      (rw_rdy),
        .rw_type     (rw_type),
        .refresh_rdy (refresh_rdy),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // record strobes with their cycle numbers, away from the active edge
    always @(negedge clk) begin
        #1;
        if (act_rdy)     act_ev.push_back(cyc);
        if (refresh_rdy) ref_ev.push_back(cyc);
        if (cas_rdy)     cas_ev.push_back('{cyc, cas_rw});
        if (rw_rdy)      rw_ev.push_back('{cyc, rw_type});
        if (int'(act_rdy) + int'(cas_rdy) + int'(refresh_rdy) > 1) excl_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int act_at(input int i);
        return (i < act_ev.size()) ? act_ev[i] : -1;
    endfunction
    function automatic int cas_at(input int i);
        return (i < cas_ev.size()) ? cas_ev[i].cyc : -1;
    endfunction
    function automatic int cas_t(input int i);
        return (i < cas_ev.size()) ? int'(cas_ev[i].t) : -1;
    endfunction
    function automatic int rw_at(input int i);
        return (i < rw_ev.size()) ? rw_ev[i].cyc : -1;
    endfunction
    function automatic int rw_t(input int i);
        return (i < rw_ev.size()) ? int'(rw_ev[i].t) : -1;
    endfunction

    // called on a falling edge; returns on a falling edge with cyc = first non-reset cycle
    task automatic do_reset();
        reset   = 1'b1;
        new_cmd = 1'b0;
        req_rw  = 2'b00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        act_ev.delete();
        ref_ev.delete();
        cas_ev.delete();
        rw_ev.delete();
    endtask

    // hold new_cmd until accepted; acc = accept cycle
    task automatic issue(input logic [1:0] rw, output int acc);
        int n = 0;
        new_cmd = 1'b1;
        req_rw  = rw;
        #1;
        while (!req_ready && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 500) chk("accept_timeout", 32'(req_ready), 32'd1);
        acc = cyc;
        @(negedge clk);
        new_cmd = 1'b0;
    endtask

    task automatic wait_rw(input int n, input int budget);
        int k = 0;
        while (rw_ev.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (rw_ev.size() < n) chk("rw_timeout", rw_ev.size(), n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, a3, a4, r0, k;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outputs", 32'({req_ready, act_rdy, cas_rdy, cas_rw, rw_rdy, rw_type, refresh_rdy, busy}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_rdy_after", 32'(req_ready), 32'd1);
        chk("rst_busy_after", 32'(busy), 32'd0);
        @(negedge clk);

        // single read: ACT at +1, CAS at +12, data at CAS+14
        do_reset();
        rd_delay = 6'd14; wr_delay = 6'd10; t_ccd = 4'd4;
        issue(2'b01, a0);
        wait_rw(1, 100);
        chk("rd_act", act_at(0), a0 + 1);
        chk("rd_cas", cas_at(0), a0 + 12);
        chk("rd_cas_rw", cas_t(0), 1);
        chk("rd_rw", rw_at(0), a0 + 26);
        chk("rd_rw_type", rw_t(0), 1);

        // write then read, back to back
        do_reset();
        issue(2'b10, a0);
        issue(2'b01, a1);
        wait_rw(2, 100);
        chk("wr_rd_acc2", a1, a0 + 13);
        chk("wr_rd_cas0", cas_at(0), a0 + 12);
        chk("wr_rd_cas1", cas_at(1), a0 + 25);
        chk("wr_rd_gap", 32'(cas_at(1) - cas_at(0) >= 4), 32'd1);
        chk("wr_rd_rw0", rw_at(0), a0 + 22);
        chk("wr_rd_t0", rw_t(0), 2);
        chk("wr_rd_rw1", rw_at(1), a0 + 39);
        chk("wr_rd_t1", rw_t(1), 1);

        // t_ccd=15 exceeds natural 13-cycle CAS spacing: second CAS slips 2
        do_reset();
        t_ccd = 4'd15;
        issue(2'b10, a0);
        issue(2'b01, a1);
        wait_rw(2, 100);
        chk("ccd_cas1", cas_at(1), a0 + 27);
        chk("ccd_rw1", rw_at(1), a0 + 41);
        t_ccd = 4'd4;

        // ordering stall: read d=30 then write d=5
        do_reset();
        rd_delay = 6'd30; wr_delay = 6'd5;
        issue(2'b01, a0);
        issue(2'b10, a1);
        wait_rw(2, 100);
        chk("ord_cas1", cas_at(1), a0 + 38);
        chk("ord_rw0", rw_at(0), a0 + 42);
        chk("ord_t0", rw_t(0), 1);
        chk("ord_rw1", rw_at(1), a0 + 43);
        chk("ord_t1", rw_t(1), 2);

        // invalid type: ACT/CAS with cas_rw=00, no data; then write with d=0 -> 1
        do_reset();
        wr_delay = 6'd0;
        issue(2'b11, a0);
        issue(2'b10, a1);
        wait_rw(1, 100);
        repeat (5) @(negedge clk);
        chk("inv_act", act_at(0), a0 + 1);
        chk("inv_cas", cas_at(0), a0 + 12);
        chk("inv_cas_rw", cas_t(0), 0);
        chk("d0_cas", cas_at(1), a0 + 25);
        chk("d0_rw", rw_at(0), a0 + 26);
        chk("d0_rw_cnt", rw_ev.size(), 1);

        // slots full: fifth read waits for the first data phase to free a slot
        do_reset();
        rd_delay = 6'd63; wr_delay = 6'd10;
        issue(2'b01, a0);
        issue(2'b01, a1);
        issue(2'b01, a2);
        issue(2'b01, a3);
        issue(2'b01, a4);
        chk("full_acc4", a3, a0 + 39);
        chk("full_rw0", rw_at(0), a0 + 75);
        chk("full_acc5", a4, a0 + 76);
        wait_rw(5, 200);
        chk("full_rw4", rw_at(4), a0 + 151);

        // reset mid-operation aborts the pending data phase
        do_reset();
        rd_delay = 6'd14;
        issue(2'b01, a0);
        k = 0;
        while (cas_ev.size() < 1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("mid_cas_seen", cas_ev.size(), 1);
        do_reset();
        repeat (30) @(negedge clk);
        #1;
        chk("mid_no_rw", rw_ev.size(), 0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_rdy", 32'(req_ready), 32'd1);
        @(negedge clk);

        // refresh interval expiring while a read is in flight
        do_reset();
        r0 = cyc;
        rd_delay = 6'd63;
        repeat (150) @(negedge clk);
        issue(2'b01, a0);
        chk("ref_acc", a0, r0 + 150);
        while (cyc < r0 + 260) begin
            @(negedge clk);
            #1;
            rdy_log[cyc - r0] = req_ready;
        end
        chk("ref_rw", rw_at(0), r0 + 225);
`ifdef DDR_SCHED_REFRESH_EN
        chk("ref_cnt", ref_ev.size(), 1);
        chk("ref_at", (ref_ev.size() > 0) ? ref_ev[0] : -1, r0 + 227);
        chk("ref_rdy_pend", 32'(rdy_log[200]), 32'd0);
        chk("ref_rdy_rfc", 32'(rdy_log[246]), 32'd0);
        chk("ref_rdy_back", 32'(rdy_log[247]), 32'd1);
`else
        chk("noref_cnt", ref_ev.size(), 0);
        chk("noref_rdy", 32'(rdy_log[200]), 32'd1);
`endif

        chk("exclusive", excl_bad, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
